// File: rtl/mem_init_pkg.sv
// Shared types and constants for the PicoRV32 native-bus command initiator.
package mem_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_init_state_e;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = 4;

  // Character-out MMIO register poked out-of-band during fuzz runs.
  localparam logic [MEM_ADDR_W-1:0] MEM_OUT_BYTE_ADDR = 32'h1000_0000;

endpackage

// File: rtl/mem_init_watchdog.sv
// REQ-phase wait counter; flags an abort on the last waiting cycle before the limit.
module mem_init_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside REQ, so every new transfer starts from a clean count.
  always_ff @(posedge clk) begin
    if (reset || !active_i) begin
      cnt_q <= '0;
    end else if (!ready_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A late mem_ready in the limit cycle wins over the abort.
  assign expired_o = active_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_initiator.sv
// Command-port to PicoRV32 native-bus initiator, one transfer outstanding at a time.
// Optional REQ timeout is built when MEM_INIT_TIMEOUT_EN is defined.
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [MEM_ADDR_W-1:0] cmd_addr,
  input  logic [MEM_DATA_W-1:0] cmd_wdata,
  input  logic [MEM_STRB_W-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  output logic                  mem_instr,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic [MEM_STRB_W-1:0] mem_wstrb,
  input  logic                  mem_ready,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; cmd, rsp and mem ports all follow this rule, and valid never waits on ready.

  mem_init_state_e       state_q;
  logic                  cmd_ready_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [MEM_DATA_W-1:0] mem_wdata_q;
  logic [MEM_STRB_W-1:0] mem_wstrb_q;
  logic [MEM_DATA_W-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  cmd_fire;
  logic                  zero_strb_wr;
  logic                  timeout;
  logic                  unused_addr_lsbs;

  assign cmd_fire         = cmd_valid && cmd_ready_q;
  assign zero_strb_wr     = cmd_write && (cmd_wstrb == '0);
  assign unused_addr_lsbs = ^cmd_addr[1:0];

`ifdef MEM_INIT_TIMEOUT_EN
  mem_init_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .active_i (state_q == ST_REQ),
    .ready_i  (mem_ready),
    .expired_o(timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            mem_addr_q  <= {cmd_addr[MEM_ADDR_W-1:2], 2'b00};
            mem_wdata_q <= cmd_wdata;
            mem_wstrb_q <= cmd_write ? cmd_wstrb : '0;
            if (zero_strb_wr) begin
              state_q     <= ST_RESP;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Writes reaching REQ always carry a non-zero strobe, so it marks the direction.
          if (mem_ready) begin
            state_q     <= ST_RESP;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= (mem_wstrb_q != '0) ? '0 : mem_rdata;
          end else if (timeout) begin
            state_q     <= ST_RESP;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign mem_valid   = (state_q == ST_REQ);
  assign mem_instr   = 1'b0;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: behavioural native-bus responder plus response scoreboard.
module tb_mem_initiator;
  import mem_init_pkg::*;

  localparam int TO_CYCLES = 8;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  mem_initiator #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- responder ----------------
  bit resp_en  = 1'b1;
  int wait_cfg = 0;
  int wait_seen = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    if (mem_valid && resp_en && !reset) begin
      if (wait_seen >= wait_cfg) begin
        mem_ready = 1'b1;
        if (mem_wstrb != 4'h0)
          bus_mem[mem_addr >> 2] = merge(bus_mem.exists(mem_addr >> 2) ? bus_mem[mem_addr >> 2] : 32'h0,
                                         mem_wdata, mem_wstrb);
        else
          mem_rdata = bus_mem.exists(mem_addr >> 2) ? bus_mem[mem_addr >> 2] : 32'h0;
        wait_seen = 0;
      end else begin
        wait_seen++;
      end
    end else begin
      wait_seen = 0;
    end
  end

  // ---------------- bus monitor ----------------
  int          bus_cycles = 0;
  int          unstable = 0;
  int          ready_while_busy = 0;
  logic [31:0] last_addr;
  logic [3:0]  last_wstrb;
  logic        prev_valid = 1'b0;
  logic [67:0] prev_req;

  always @(negedge clk) begin
    if (mem_valid) begin
      if (prev_valid && ({mem_addr, mem_wdata, mem_wstrb} !== prev_req)) unstable++;
      bus_cycles++;
      last_addr  = mem_addr;
      last_wstrb = mem_wstrb;
    end
    prev_valid = mem_valid;
    prev_req   = {mem_addr, mem_wdata, mem_wstrb};
    if (busy && cmd_ready) ready_while_busy++;
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    int unsigned idx;
    logic [31:0] old;
    idx = a >> 2;
    old = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (w && s == 4'h0) exp_q.push_back({1'b1, 32'h0});
    else if (w) begin
      ref_mem[idx] = merge(old, d, s);
      exp_q.push_back({1'b0, 32'h0});
    end else exp_q.push_back({1'b0, old});
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a >> 2] = d;
    bus_mem[a >> 2] = d;
  endtask

  // Offers a command, returns one time-step after the accepting edge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    bit accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin accepted = 1'b1; break; end
    end
    n_cmp++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 100 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    bus_cycles = 0;
  endtask

  // Waits for a response, compares it against the scoreboard head, then consumes it.
  task automatic get_rsp(input string name, output int lat);
    logic [32:0] exp;
    logic        keep;
    bit          seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_rsp_timeout: got rsp_valid=0 for 200 cycles, expected 1", name);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected_rsp: got %h, expected no response", name, {rsp_err, rsp_rdata});
    end else begin
      exp = exp_q.pop_front();
      if ({rsp_err, rsp_rdata} !== exp) begin
        n_fail++;
        $display("FAIL %s_rsp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                 name, rsp_err, rsp_rdata, exp[32], exp[31:0]);
      end
      keep      = rsp_ready;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = keep;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, rsp_valid,
         rsp_rdata, rsp_err, busy, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b mv=%0b addr=%h wd=%h ws=%h rv=%0b rd=%h err=%0b busy=%0b st=%0d, expected all 0",
               cmd_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, rsp_valid, rsp_rdata,
               rsp_err, busy, dbg_state);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    int lat;
    wait_cfg = 0;
    push_expected(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    get_rsp("zw_write", lat);
    n_cmp++;
    if (last_addr !== 32'h10 || last_wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL zw_write_bus: got addr=%h wstrb=%h, expected 00000010 f", last_addr, last_wstrb);
    end
    push_expected(1'b0, 32'h13, 32'h0, 4'h0);
    send_cmd(1'b0, 32'h13, 32'h0, 4'hF);
    get_rsp("zw_read", lat);
    n_cmp++;
    if (last_addr !== 32'h10 || last_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL zw_read_bus: got addr=%h wstrb=%h, expected 00000010 0", last_addr, last_wstrb);
    end
    n_cmp++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL zw_latency: got %0d cycles, expected 2", lat);
    end
  endtask

  task automatic test_wait_states();
    int lat;
    preload(32'h20, 32'h12345678);
    wait_cfg = 3;
    unstable = 0;
    push_expected(1'b0, 32'h20, 32'h0, 4'h0);
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    get_rsp("ws_read", lat);
    n_cmp++;
    if (bus_cycles !== 4 || unstable !== 0 || last_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL ws_bus: got cycles=%0d unstable=%0d addr=%h, expected 4 0 00000020",
               bus_cycles, unstable, last_addr);
    end
    n_cmp++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL ws_latency: got %0d cycles, expected 5", lat);
    end
    wait_cfg = 0;
  endtask

  task automatic test_mmio_write();
    int lat;
    ready_while_busy = 0;
    push_expected(1'b1, MEM_OUT_BYTE_ADDR, 32'h41, 4'b0001);
    send_cmd(1'b1, MEM_OUT_BYTE_ADDR, 32'h41, 4'b0001);
    get_rsp("mmio", lat);
    n_cmp++;
    if (bus_cycles !== 1 || last_wstrb !== 4'b0001 || last_addr !== MEM_OUT_BYTE_ADDR) begin
      n_fail++;
      $display("FAIL mmio_bus: got cycles=%0d wstrb=%h addr=%h, expected 1 1 10000000",
               bus_cycles, last_wstrb, last_addr);
    end
    n_cmp++;
    if (bus_mem[MEM_OUT_BYTE_ADDR >> 2][7:0] !== 8'h41 || ready_while_busy !== 0) begin
      n_fail++;
      $display("FAIL mmio_effect: got byte=%h ready_while_busy=%0d, expected 41 0",
               bus_mem[MEM_OUT_BYTE_ADDR >> 2][7:0], ready_while_busy);
    end
  endtask

  task automatic test_zero_strobe();
    int lat;
    push_expected(1'b1, 32'h30, 32'hCAFEF00D, 4'h0);
    send_cmd(1'b1, 32'h30, 32'hCAFEF00D, 4'h0);
    get_rsp("zs", lat);
    n_cmp++;
    if (bus_cycles !== 0 || lat !== 1) begin
      n_fail++;
      $display("FAIL zs_timing: got bus_cycles=%0d latency=%0d, expected 0 1", bus_cycles, lat);
    end
  endtask

  task automatic test_rsp_hold();
    int lat;
    bit seen;
    preload(32'h24, 32'hA5A5_0F0F);
    push_expected(1'b0, 32'h24, 32'h0, 4'h0);
    send_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h28; cmd_wstrb = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (!seen || rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0F0F || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got rv=%0b rd=%h rdy=%0b, expected 1 a5a50f0f 0",
                 i, rsp_valid, rsp_rdata, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    get_rsp("hold", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic        w;
    logic [31:0] a, d;
    logic [3:0]  s;
    rsp_ready = 1'b1;
    unstable = 0;
    ready_while_busy = 0;
    push_expected(1'b0, 32'h10, 32'h0, 4'h0);
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp("b2b_first", lat);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_resp_one_cycle: got rv=%0b rdy=%0b, expected 0 1", rsp_valid, cmd_ready);
    end
    for (int k = 0; k < 24; k++) begin
      w = 1'(($urandom_range(0, 1)));
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wait_cfg = $urandom_range(0, 2);
      push_expected(w, a, d, s);
      send_cmd(w, a, d, s);
      get_rsp("b2b_rand", lat);
    end
    rsp_ready = 1'b0;
    wait_cfg  = 0;
    n_cmp++;
    if (unstable !== 0 || ready_while_busy !== 0) begin
      n_fail++;
      $display("FAIL b2b_invariants: got unstable=%0d ready_while_busy=%0d, expected 0 0",
               unstable, ready_while_busy);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    resp_en = 1'b0;
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_in_req: got mem_valid=%0b, expected 1", mem_valid);
    end
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_after: got mv=%0b rv=%0b busy=%0b, expected 0 0 0", mem_valid, rsp_valid, busy);
    end
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL rmid_no_rsp: got %0d response cycles, expected 0", stray);
    end
    resp_en = 1'b1;
  endtask

`ifdef MEM_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    resp_en = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 32'h50, 32'h0, 4'h0);
    get_rsp("to_abort", lat);
    n_cmp++;
    if (bus_cycles !== TO_CYCLES) begin
      n_fail++;
      $display("FAIL to_cycles: got %0d REQ cycles, expected %0d", bus_cycles, TO_CYCLES);
    end
    resp_en  = 1'b1;
    wait_cfg = TO_CYCLES - 1;
    preload(32'h54, 32'h0BADCAFE);
    push_expected(1'b0, 32'h54, 32'h0, 4'h0);
    send_cmd(1'b0, 32'h54, 32'h0, 4'h0);
    get_rsp("to_limit_ready", lat);
    n_cmp++;
    if (bus_cycles !== TO_CYCLES) begin
      n_fail++;
      $display("FAIL to_limit_cycles: got %0d REQ cycles, expected %0d", bus_cycles, TO_CYCLES);
    end
    wait_cfg = 0;
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_mmio_write();
    test_zero_strobe();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_INIT_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d unconsumed entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Command-driven initiator for the PicoRV32 native memory interface (`mem_valid`/`mem_ready` handshake). It converts one-at-a-time read/write commands from a harness-side valid/ready port into native-bus transfers, and returns read data and status on a response port. It drives the same memory/MMIO responders the core drives. It is used for test-bench program preload, memory readback after `trap`, and out-of-band MMIO pokes (e.g. 0x1000_0000) during fuzz runs.

## Interface
- `TIMEOUT_CYCLES`, 1024: number of REQ cycles without `mem_ready` before the transfer aborts; used only with `MEM_INIT_TIMEOUT_EN`; minimum 1.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on a cycle where both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address; bits [1:0] ignored.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: byte enables for writes; ignored for reads.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed on a cycle where both `rsp_valid` and `rsp_ready` are high.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: transfer failed.
- `mem_valid` out 1, `mem_instr` out 1 (constant 0), `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: native-bus request.
- `mem_ready` in 1, `mem_rdata` in 32: native-bus completion.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, REQ and RESP. Only one command is outstanding at a time.
- **IDLE**
  - `cmd_ready` = 1, except while `reset` is high.
  - On accept, register the request:
    - `mem_addr` = {`cmd_addr`[31:2], 2'b00}.
    - `mem_wdata` = `cmd_wdata`.
    - `mem_wstrb` = `cmd_write` ? `cmd_wstrb` : 4'b0000.
  - Then go to REQ.
  - Exception: a write with `cmd_wstrb` == 0 issues no bus cycle. The block goes straight to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
- **REQ**
  - `mem_valid` = 1. Address, data and strobe stay stable for the whole state.
  - When `mem_ready` is sampled high:
    - `rsp_rdata` = `mem_rdata` for reads, or 0 for writes.
    - `rsp_err` = 0.
    - `mem_valid` drops at the same edge, and the state goes to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` stay stable until the `rsp_valid`/`rsp_ready` handshake completes, then the state returns to IDLE.
- `mem_ready` is ignored outside REQ.
- `mem_wdata`/`mem_wstrb`/`mem_addr` retain their last values outside REQ. No responder may rely on them while `mem_valid` = 0.

## Timing
- All of these are 0 after any cycle with `reset` high: `cmd_ready`, `mem_valid`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy`. The state is IDLE.
- Command accepted at edge N → `mem_valid` high in cycle N+1.
- `mem_ready` sampled at edge M (M ≥ N+1) → `rsp_valid` high in cycle M+1.
- With a zero-wait responder, accept to `rsp_valid` is 2 cycles, and a back-to-back command is accepted no earlier than one cycle after the response handshake.
- If `rsp_ready` is held high, RESP lasts exactly 1 cycle.
- `reset` mid-transfer drops `mem_valid` at the next edge and discards any pending response. A `mem_ready` arriving in the reset cycle is ignored.
- `mem_ready` asserted in the first REQ cycle completes the transfer. The responder must not assert `mem_ready` for a transfer before it sees `mem_valid`.

## Configuration
- **`MEM_INIT_TIMEOUT_EN` defined**
  - A counter of width $clog2(`TIMEOUT_CYCLES`+1) clears on entry to REQ and increments on each REQ cycle without `mem_ready`.
  - When it reaches `TIMEOUT_CYCLES`, `mem_valid` drops and the state goes to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - If `mem_ready` arrives in the same cycle the limit is reached, the transfer completes normally (`rsp_err` = 0).
- **Not defined**
  - No counter. REQ waits indefinitely.
  - `rsp_err` is set only by zero-strobe writes.

## Structure
- Package `mem_init_pkg` holds:
  - The state enum (IDLE/REQ/RESP).
  - The localparams `MEM_ADDR_W` = 32, `MEM_DATA_W` = 32, `MEM_STRB_W` = 4.
  - The MMIO constant `MEM_OUT_BYTE_ADDR` = 32'h1000_0000.
- One sub-module, `mem_init_watchdog`: the timeout counter. It is instantiated only under `MEM_INIT_TIMEOUT_EN`.

## Test plan
- Zero-wait responder: write addr 0x0000_0010, data 0xDEADBEEF, wstrb 4'hF; then read 0x0000_0013 → `mem_addr` = 0x10 on both transfers, `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, accept-to-`rsp_valid` = 2 cycles.
- Responder inserts 3 wait cycles on a read of 0x20 returning 0x12345678 → `mem_valid`/`mem_addr` stable for 4 cycles, `rsp_valid` one cycle after `mem_ready`, `rsp_rdata` = 0x12345678.
- Write 0x1000_0000, data 0x41, wstrb 4'b0001 → one bus cycle with `mem_wstrb` = 4'b0001; `rsp_rdata` = 0; `cmd_ready` stays low until the response handshake.
- Write with wstrb 0 → `mem_valid` never asserts; `rsp_valid` next cycle with `rsp_err` = 1.
- `rsp_ready` held low for 5 cycles → `rsp_valid`/`rsp_rdata` held; a second `cmd_valid` is not accepted.
- `MEM_INIT_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, `mem_ready` never asserted → `mem_valid` drops after 8 REQ cycles, `rsp_err` = 1. Separately, `reset` asserted in REQ → `mem_valid` = 0 next cycle, no response emitted.
